// File: rtl/led_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_scan_ctrl_if
// Bundles the host load interface and the display-side outputs of the LED
// scan controller.
//   master : the host. Drives load/digits_in/dots_in/en_in/lz_sup and
//            observes the display outputs.
//   slave  : the scan controller. Receives the frame data and drives
//            dig_ctrl/blank/digit_sel_n/frame_start/upd_done.
// Signals:
//   load         one-cycle strobe, captures the frame inputs into pending
//   digits_in    4 bits per digit, digit k at [4k+3:4k], k=0 rightmost
//   dots_in      decimal point flag per digit
//   en_in        per-digit enable, 0 keeps that digit dark
//   lz_sup       leading-zero suppression, sampled live
//   dig_ctrl     {dot, nibble} of the digit in the current slot
//   blank        high during the blanking window of each slot
//   digit_sel_n  active-low digit select
//   frame_start  pulse on the first cycle of slot 0
//   upd_done     pulse when pending data has been committed
// ---------------------------------------------------------------------------
interface led_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dots_in;
    logic [NUM_DIGITS-1:0]   en_in;
    logic                    lz_sup;
    logic [4:0]              dig_ctrl;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   digit_sel_n;
    logic                    frame_start;
    logic                    upd_done;

    modport master (
        output load, digits_in, dots_in, en_in, lz_sup,
        input  dig_ctrl, blank, digit_sel_n, frame_start, upd_done
    );

    modport slave (
        input  load, digits_in, dots_in, en_in, lz_sup,
        output dig_ctrl, blank, digit_sel_n, frame_start, upd_done
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_scan_ctrl
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Holds a double-buffered frame (digits, dots, enables), steps
// through the digits one slot at a time and opens a blanking window at the
// start of each slot to avoid ghosting. New frame data is committed only at
// a frame boundary, so a frame never mixes old and new data.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  led_scan_ctrl_if.slave (load handshake in, display drive out)
// Parameters:
//   NUM_DIGITS 2..8, SCAN_DIV >= 2 cycles per slot,
//   BLANK_CYC  0 < BLANK_CYC < SCAN_DIV blanking cycles per slot
// ---------------------------------------------------------------------------
module led_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic           clk,
    input  logic           rst,
    led_scan_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK_END = PRE_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

    // Scan position
    logic [PRE_W-1:0] pre_q, pre_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;

    // Active (displayed) and pending (loaded, not yet shown) frames
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_nxt, pend_digits_q;
    logic [NUM_DIGITS-1:0]   act_dots_q,   act_dots_nxt,   pend_dots_q;
    logic [NUM_DIGITS-1:0]   act_en_q,     act_en_nxt,     pend_en_q;
    logic                    pend_valid_q;

    // Registered outputs
    logic [4:0]            dig_ctrl_q;
    logic                  blank_q;
    logic [NUM_DIGITS-1:0] sel_n_q;
    logic                  frame_start_q;
    logic                  upd_done_q;

    logic                  wrap;
    logic                  commit;
    logic [NUM_DIGITS-1:0] visible;
    logic                  lit_above;
    logic                  zero_code;
    logic                  suppressed;
    logic [NUM_DIGITS-1:0] sel_n_nxt;

    assign wrap   = (pre_q == PRE_LAST);
    assign commit = wrap && (idx_q == IDX_LAST) && pend_valid_q;

    assign pre_nxt = wrap ? '0 : pre_q + 1'b1;
    assign idx_nxt = !wrap ? idx_q : ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1);

    assign act_digits_nxt = commit ? pend_digits_q : act_digits_q;
    assign act_dots_nxt   = commit ? pend_dots_q   : act_dots_q;
    assign act_en_nxt     = commit ? pend_en_q     : act_en_q;

    // Outputs are registered from the next-state view of the scan position
    // and active frame, so they line up with the cycle in which the
    // prescaler reads a given value, and a committed frame appears from the
    // first cycle of slot 0.
    //
    // Leading-zero suppression: walking down from the top digit, a blank
    // digit (nibble 0, no dot) stays dark while no enabled digit above it
    // has been lit. Disabled digits are transparent to the walk.
    always_comb begin
        // NOTE: every variable gets a default before the loop so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        visible    = '0;
        lit_above  = 1'b0;
        zero_code  = 1'b0;
        suppressed = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_code  = (act_digits_nxt[4*k +: 4] == 4'h0) && !act_dots_nxt[k];
            suppressed = bus.lz_sup && (k != 0) && zero_code && !lit_above;
            visible[k] = act_en_nxt[k] && !suppressed;
            if (visible[k]) begin
                lit_above = 1'b1;
            end
        end
    end

    always_comb begin
        sel_n_nxt = '1;
        if ((pre_nxt >= PRE_BLANK_END) && visible[idx_nxt]) begin
            sel_n_nxt[idx_nxt] = 1'b0;
        end
    end

    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q         <= '0;
            idx_q         <= '0;
            // NOTE: the frame buffers are plain flops and are cleared here so
            // the display stays dark until a load has been committed.
            act_digits_q  <= '0;
            act_dots_q    <= '0;
            act_en_q      <= '0;
            pend_digits_q <= '0;
            pend_dots_q   <= '0;
            pend_en_q     <= '0;
            pend_valid_q  <= 1'b0;
            dig_ctrl_q    <= '0;
            blank_q       <= 1'b1;
            sel_n_q       <= '1;
            frame_start_q <= 1'b0;
            upd_done_q    <= 1'b0;
        end else begin
            pre_q        <= pre_nxt;
            idx_q        <= idx_nxt;
            act_digits_q <= act_digits_nxt;
            act_dots_q   <= act_dots_nxt;
            act_en_q     <= act_en_nxt;

            // A load on the boundary cycle still becomes pending: the old
            // pending frame commits and the new one waits for the next boundary.
            if (bus.load) begin
                pend_digits_q <= bus.digits_in;
                pend_dots_q   <= bus.dots_in;
                pend_en_q     <= bus.en_in;
                pend_valid_q  <= 1'b1;
            end else if (commit) begin
                pend_valid_q  <= 1'b0;
            end

            dig_ctrl_q    <= {act_dots_nxt[idx_nxt], act_digits_nxt[{idx_nxt, 2'b00} +: 4]};
            blank_q       <= (pre_nxt < PRE_BLANK_END);
            sel_n_q       <= sel_n_nxt;
            frame_start_q <= (pre_nxt == '0) && (idx_nxt == '0);
            upd_done_q    <= commit;
        end
    end

    assign bus.dig_ctrl    = dig_ctrl_q;
    assign bus.blank       = blank_q;
    assign bus.digit_sel_n = sel_n_q;
    assign bus.frame_start = frame_start_q;
    assign bus.upd_done    = upd_done_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_scan_ctrl
// Self-checking bench for led_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYC=2. A cycle-count based reference model predicts every output on
// every cycle; directed scenarios add literal expectations, followed by a
// randomized phase of loads, lz_sup changes and resets.
// ---------------------------------------------------------------------------
module tb_led_scan_ctrl;
    localparam int N     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    led_scan_ctrl #(
        .NUM_DIGITS(N),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time since reset release, t, fully determines the scan position:
    // slot phase = t % SD, digit = (t / SD) % N.
    int              m_t;
    logic [4*N-1:0]  m_act_d,  m_pend_d;
    logic [N-1:0]    m_act_dp, m_pend_dp, m_act_en, m_pend_en;
    bit              m_pv;
    logic [4:0]      e_dig;
    logic            e_blank, e_fs, e_upd;
    logic [N-1:0]    e_sel;

    // A digit is suppressed when lz is on, it is not digit 0, its code is
    // blank and it lies above the highest enabled digit with a non-blank code.
    function automatic logic [N-1:0] vis_mask(input logic [4*N-1:0] d, input logic [N-1:0] dp,
                                              input logic [N-1:0] en, input logic lz);
        int top = -1;
        logic [N-1:0] v;
        for (int j = 0; j < N; j++)
            if (en[j] && (d[4*j +: 4] != 4'h0 || dp[j])) top = j;
        for (int j = 0; j < N; j++)
            v[j] = en[j] && !(lz && j != 0 && d[4*j +: 4] == 4'h0 && !dp[j] && j > top);
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int tn, p, k;
        bit upd;
        logic [4*N-1:0] ad;
        logic [N-1:0] adp, aen, vis;
        if (rst) begin
            m_t <= 0;
            m_act_d <= '0;  m_act_dp <= '0;  m_act_en <= '0;
            m_pend_d <= '0; m_pend_dp <= '0; m_pend_en <= '0;
            m_pv <= 1'b0;
            e_dig <= '0; e_blank <= 1'b1; e_sel <= '1; e_fs <= 1'b0; e_upd <= 1'b0;
        end else begin
            ad = m_act_d; adp = m_act_dp; aen = m_act_en;
            upd = 1'b0;
            if ((m_t % SD == SD - 1) && ((m_t / SD) % N == N - 1) && m_pv) begin
                ad = m_pend_d; adp = m_pend_dp; aen = m_pend_en;
                upd = 1'b1;
            end
            if (bus.load) begin
                m_pend_d <= bus.digits_in; m_pend_dp <= bus.dots_in; m_pend_en <= bus.en_in;
                m_pv <= 1'b1;
            end else if (upd) begin
                m_pv <= 1'b0;
            end
            tn = m_t + 1;
            p  = tn % SD;
            k  = (tn / SD) % N;
            vis = vis_mask(ad, adp, aen, bus.lz_sup);
            m_act_d <= ad; m_act_dp <= adp; m_act_en <= aen;
            m_t     <= tn;
            e_dig   <= {adp[k], ad[4*k +: 4]};
            e_blank <= (p < BC);
            e_sel   <= (p >= BC && vis[k]) ? ~(N'(1) << k) : '1;
            e_fs    <= (p == 0 && k == 0);
            e_upd   <= upd;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("dig_ctrl",    32'(bus.dig_ctrl),    32'(e_dig));
            check("blank",       32'(bus.blank),       32'(e_blank));
            check("digit_sel_n", 32'(bus.digit_sel_n), 32'(e_sel));
            check("frame_start", 32'(bus.frame_start), 32'(e_fs));
            check("upd_done",    32'(bus.upd_done),    32'(e_upd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Advance at least one cycle, then until the scan reaches phase p of slot k.
    task automatic goto(input int p, input int k);
        int guard = 0;
        tick();
        while (!((m_t % SD) == p && ((m_t / SD) % N) == k)) begin
            tick();
            guard++;
            if (guard > 2 * FRAME) begin
                errors++;
                $display("FAIL goto_timeout: phase %0d slot %0d not reached", p, k);
                return;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        bus.load      = 1'b1;
        bus.digits_in = d;
        bus.dots_in   = dp;
        bus.en_in     = en;
        tick();
        bus.load      = 1'b0;
    endtask

    initial begin
        int n, first_t, last_t;
        bus.load = 1'b0; bus.digits_in = '0; bus.dots_in = '0; bus.en_in = '0; bus.lz_sup = 1'b0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        #20;
        @(posedge clk); #2;
        rst = 1'b0;

        // Reset state
        check("rst_dig", 32'(bus.dig_ctrl), 32'h0);
        check("rst_blank", 32'(bus.blank), 32'h1);
        check("rst_sel", 32'(bus.digit_sel_n), 32'hF);
        check("rst_fs", 32'(bus.frame_start), 32'h0);
        check("rst_upd", 32'(bus.upd_done), 32'h0);

        // frame_start every 32 cycles
        n = 0; first_t = -1; last_t = -1;
        for (int i = 1; i <= 3 * FRAME; i++) begin
            tick();
            if (bus.frame_start) begin
                n++;
                if (first_t < 0) first_t = m_t;
                last_t = m_t;
            end
        end
        check("fs_count", n, 3);
        check("fs_first", first_t, FRAME);
        check("fs_period", last_t - first_t, 2 * FRAME);

        // Load commit
        goto(3, 1);
        do_load(16'h4321, 4'b0010, 4'hF);
        goto(0, 0);
        check("commit_upd", 32'(bus.upd_done), 32'h1);
        check("commit_slot0", 32'(bus.dig_ctrl), 32'h01);
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (bus.upd_done) n++;
        end
        check("upd_once", n, 0);
        goto(1, 0); check("sel0_blank", 32'(bus.digit_sel_n), 32'hF);
        goto(2, 0); check("sel0", 32'(bus.digit_sel_n), 32'hE);
        goto(1, 1); check("slot1_dig", 32'(bus.dig_ctrl), 32'h12);
        check("slot1_blank", 32'(bus.blank), 32'h1);
        goto(2, 1); check("sel1", 32'(bus.digit_sel_n), 32'hD);
        goto(7, 2); check("sel2", 32'(bus.digit_sel_n), 32'hB);
        goto(2, 3); check("slot3_dig", 32'(bus.dig_ctrl), 32'h04);
        check("sel3", 32'(bus.digit_sel_n), 32'h7);

        // Leading-zero suppression
        bus.lz_sup = 1'b1;
        goto(3, 1);
        do_load(16'h0050, 4'b0000, 4'hF);
        goto(0, 0);
        n = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (!bus.digit_sel_n[3] || !bus.digit_sel_n[2]) n++;
        end
        check("lz_hidden", n, 0);
        goto(4, 1); check("lz_d1_dig", 32'(bus.dig_ctrl), 32'h05);
        check("lz_d1_sel", 32'(bus.digit_sel_n), 32'hD);
        goto(4, 0); check("lz_d0_dig", 32'(bus.dig_ctrl), 32'h00);
        check("lz_d0_sel", 32'(bus.digit_sel_n), 32'hE);
        goto(3, 1);
        do_load(16'h0050, 4'b1000, 4'hF);
        goto(0, 0);
        goto(4, 2); check("lz_d2_vis", 32'(bus.digit_sel_n), 32'hB);
        goto(4, 3); check("lz_d3_vis", 32'(bus.digit_sel_n), 32'h7);
        check("lz_d3_dig", 32'(bus.dig_ctrl), 32'h10);

        // Double buffering: last load in a frame wins
        goto(2, 1);
        do_load(16'h1111, 4'b0000, 4'hF);
        goto(4, 2);
        do_load(16'h2222, 4'b0000, 4'hF);
        n = 0; first_t = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (bus.upd_done) n++;
            if (bus.dig_ctrl == 5'h01) first_t++;
        end
        check("dbuf_upd", n, 1);
        check("dbuf_no_1111", first_t, 0);
        goto(4, 0); check("dbuf_dig", 32'(bus.dig_ctrl), 32'h02);

        // Load exactly on the boundary cycle, nothing pending
        goto(7, 3);
        do_load(16'h3333, 4'b0000, 4'hF);
        check("bnd_upd0", 32'(bus.upd_done), 32'h0);
        check("bnd_old", 32'(bus.dig_ctrl), 32'h02);
        goto(0, 0);
        check("bnd_upd1", 32'(bus.upd_done), 32'h1);
        check("bnd_new", 32'(bus.dig_ctrl), 32'h03);

        // Load on the boundary with data already pending
        goto(3, 2);
        do_load(16'h4444, 4'b0000, 4'hF);
        goto(7, 3);
        do_load(16'h5555, 4'b0000, 4'hF);
        check("bnd2_upd", 32'(bus.upd_done), 32'h1);
        check("bnd2_old", 32'(bus.dig_ctrl), 32'h04);
        goto(0, 0);
        check("bnd2_upd_next", 32'(bus.upd_done), 32'h1);
        check("bnd2_new", 32'(bus.dig_ctrl), 32'h05);

        // Disabled digit
        bus.lz_sup = 1'b0;
        goto(3, 1);
        do_load(16'h5678, 4'b0000, 4'b1011);
        goto(0, 0);
        n = 0; first_t = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (!bus.digit_sel_n[2]) n++;
            if (bus.dig_ctrl == 5'h06) first_t++;
        end
        check("dis_sel2", n, 0);
        check("dis_dig_cycles", first_t, SD);
        goto(3, 3); check("dis_sel3", 32'(bus.digit_sel_n), 32'h7);

        // Reset mid-slot
        goto(4, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_blank", 32'(bus.blank), 32'h1);
        check("mid_rst_sel", 32'(bus.digit_sel_n), 32'hF);
        check("mid_rst_dig", 32'(bus.dig_ctrl), 32'h0);
        tick();
        rst = 1'b0;
        goto(4, 1);
        check("post_rst_dark", 32'(bus.digit_sel_n), 32'hF);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.load      = 1'b1;
                bus.digits_in = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'hFFFF);
                bus.dots_in   = 4'($urandom) & 4'($urandom);
                bus.en_in     = 4'($urandom) | 4'($urandom);
            end else begin
                bus.load = 1'b0;
            end
            if ($urandom_range(0, 40) == 0) bus.lz_sup = ~bus.lz_sup;
            rst = ($urandom_range(0, 1500) == 0);
            tick();
        end
        bus.load = 1'b0;
        rst = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
